seq_detect_param: RTL and testbench
===================================

Name: seq_detect_param

Overview:
- Parametrised serial bit-pattern detector; successor to the fixed-pattern `sequence` detector (ports x, clk, rst, z).
- Pattern length is a parameter. Pattern, don't-care mask and overlap mode are runtime-loadable.
- Adds an input-valid qualifier and a saturating match counter.
- Sits on the serial input path of the RTL-challenge designs and feeds match pulses to downstream control logic and benches.

Parameters:
- LEN, 4, pattern length in bits (2..32).
- PATTERN_INIT, 4'b0110, pattern after reset (LEN bits; MSB = oldest bit).
- OVERLAP_INIT, 1, overlap mode after reset (1 = overlapping, 0 = non-overlapping).
- CNT_W, 8, width of the match counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- x_valid  in  1  qualifies x; a bit is consumed only on an edge with x_valid=1.
- x  in  1  serial data bit.
- cfg_load  in  1  one-cycle strobe; latches cfg_pattern, cfg_mask and cfg_overlap, and flushes history.
- cfg_pattern  in  LEN  new pattern; bit LEN-1 is matched against the oldest bit.
- cfg_mask  in  LEN  1 = compare this bit, 0 = don't-care.
- cfg_overlap  in  1  new overlap mode.
- cnt_clr  in  1  synchronous clear of match_cnt.
- z  out  1  registered one-cycle match pulse.
- match_cnt  out  CNT_W  saturating count of matches.

Behaviour:
- Reset (rst=1 at an edge):
  - hist=0, fill=0, z=0, match_cnt=0.
  - pat=PATTERN_INIT, mask=all ones, ovl=OVERLAP_INIT.
  - All other inputs are ignored.
- Consuming a bit (edge with x_valid=1 and cfg_load=0):
  - hist_n = {hist[LEN-2:0], x}.
  - fill_n = min(fill+1, LEN); fill is $clog2(LEN+1) bits wide.
- Match condition: match = x_valid & ~cfg_load & (fill_n == LEN) & (((hist_n ^ pat) & mask) == 0).
- z output:
  - z <= match, so z is high for exactly the one cycle following the edge that consumed the final pattern bit.
  - Latency is 1 clock. z=0 on every edge that does not consume a bit.
- Overlap mode:
  - ovl=1: after a match, fill stays at LEN, so the next bit can complete another match.
  - ovl=0: on a match, fill <= 0 while hist still shifts. The next match needs LEN fresh bits.
- Idle behaviour: x_valid=0 holds hist and fill unchanged; a gap does not break a partial pattern.
- Mask all zeros: every consumed bit with fill_n==LEN matches.
- cfg_load:
  - Takes priority over x_valid; a bit presented in the same cycle is discarded.
  - pat/mask/ovl <= cfg_*; hist <= 0; fill <= 0; z <= 0.
  - match_cnt is unaffected.
- match_cnt:
  - Increments on each match; saturates at 2^CNT_W-1 (no wrap).
  - cnt_clr has priority over a simultaneous match: the count becomes 0 and that match is not counted. z still pulses.
- Reset mid-pattern discards all history; the first match after reset needs LEN fresh valid bits.
- Arithmetic is unsigned. There are no combinational input-to-output paths.

Decomposition:
- seq_det_pkg holds:
  - localparam OVL_ON=1'b1 and OVL_OFF=1'b0;
  - a function fill_width(LEN) returning $clog2(LEN+1);
  - a typedef for the config bundle {pattern, mask, overlap}.
- Sub-module seq_det_sat_cnt (CNT_W; inputs inc and clr, clr wins; output count) holds the saturating counter so other detectors can reuse it.
- Shift history, fill counter and compare stay in the top module.

Test Plan:
- Default config (0110, overlap, mask all ones), x_valid=1, stream 0,0,1,1,0,1,1,0,0,1,1,0 starting after rst drops -> z pulses after bits 4, 7 and 11 (0-based); match_cnt=3.
- Same stream after cfg_load with pattern 0110, cfg_overlap=0 -> z pulses after bits 4 and 11 only; match_cnt ends at 2 (counter not cleared by cfg_load, so 3+2=5 if run back-to-back without cnt_clr; the bench must pulse cnt_clr first and expect 2).
- LEN=5 build, pattern 11011: stream 1,1,0,1,1,0,1,1 with overlap -> z after bits 4 and 7. Without overlap -> z after bit 4 only.
- Gaps in valid: stream 0,1,(x_valid=0 for 3 cycles with x=1),1,0 -> exactly one z pulse, 1 cycle after the final 0. cfg_load in mid-stream -> no match until 4 new bits.
- Mask 4'b1001, pattern 0xx0: stream 0,1,0,0 -> match. Stream 0,0,1,1 -> no match.
- CNT_W=2: feed 5 matches -> match_cnt saturates at 3. cnt_clr on the same edge as a match -> match_cnt=0 and z=1. rst mid-pattern -> z stays 0 for at least LEN valid bits.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the parametrised serial pattern detector family.
package seq_det_pkg;

    localparam logic OVL_ON  = 1'b1;
    localparam logic OVL_OFF = 1'b0;
    localparam int   MAX_LEN = 32;

    // Pattern/mask held zero-extended to MAX_LEN so one bundle type serves every LEN.
    typedef struct packed {
        logic [MAX_LEN-1:0] pattern;
        logic [MAX_LEN-1:0] mask;
        logic               overlap;
    } seq_cfg_t;

    function automatic int fill_width(input int len);
        return $clog2(len + 1);
    endfunction

endpackage

// File: rtl/seq_det_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module seq_det_sat_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr)
            count <= '0;
        else if (inc && (count != {CNT_W{1'b1}}))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/seq_detect_param.sv
// Serial bit-pattern detector with runtime pattern/mask/overlap, valid qualifier
// and saturating match counter. z is a registered one-cycle match pulse.
module seq_detect_param
    import seq_det_pkg::*;
#(
    parameter int             LEN          = 4,
    parameter logic [LEN-1:0] PATTERN_INIT = 4'b0110,
    parameter logic           OVERLAP_INIT = OVL_ON,
    parameter int             CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x_valid,
    input  logic             x,
    input  logic             cfg_load,
    input  logic [LEN-1:0]   cfg_pattern,
    input  logic [LEN-1:0]   cfg_mask,
    input  logic             cfg_overlap,
    input  logic             cnt_clr,
    output logic             z,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int             FW   = fill_width(LEN);
    localparam logic [FW-1:0]  FULL = FW'(LEN);

    seq_cfg_t       cfg;
    logic [LEN-1:0] hist, hist_n;
    logic [FW-1:0]  fill, fill_n;
    logic           consume, match;

    assign consume = x_valid & ~cfg_load;
    assign hist_n  = {hist[LEN-2:0], x};
    assign fill_n  = (fill == FULL) ? fill : fill + 1'b1;
    // Upper bits of the stored mask are zero, so the wide compare only sees LEN bits.
    assign match   = consume && (fill_n == FULL) &&
                     (((MAX_LEN'(hist_n) ^ cfg.pattern) & cfg.mask) == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            hist        <= '0;
            fill        <= '0;
            z           <= 1'b0;
            cfg.pattern <= MAX_LEN'(PATTERN_INIT);
            cfg.mask    <= MAX_LEN'({LEN{1'b1}});
            cfg.overlap <= OVERLAP_INIT;
        end else if (cfg_load) begin
            hist        <= '0;
            fill        <= '0;
            z           <= 1'b0;
            cfg.pattern <= MAX_LEN'(cfg_pattern);
            cfg.mask    <= MAX_LEN'(cfg_mask);
            cfg.overlap <= cfg_overlap;
        end else begin
            z <= match;
            if (x_valid) begin
                hist <= hist_n;
                // Non-overlapping: history keeps shifting but LEN fresh bits are required.
                fill <= (match && cfg.overlap == OVL_OFF) ? '0 : fill_n;
            end
        end
    end

    seq_det_sat_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (match),
        .clr   (cnt_clr),
        .count (match_cnt)
    );

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: three builds (LEN=4, LEN=4/CNT_W=2, LEN=5) checked
// every cycle against a queue-based reference model, directed then random stimulus.
module tb_seq_detect_param;

    logic clk = 1'b0;
    logic rst, x_valid, x, cfg_load, cfg_overlap, cnt_clr;
    logic [3:0] p4, m4;
    logic [4:0] p5, m5;
    logic       z4, z2, z5;
    logic [7:0] c4, c5;
    logic [1:0] c2;

    always #5 clk = ~clk;

    seq_detect_param #(.LEN(4)) dut4 (
        .clk(clk), .rst(rst), .x_valid(x_valid), .x(x), .cfg_load(cfg_load),
        .cfg_pattern(p4), .cfg_mask(m4), .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
        .z(z4), .match_cnt(c4));

    seq_detect_param #(.LEN(4), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .x_valid(x_valid), .x(x), .cfg_load(cfg_load),
        .cfg_pattern(p4), .cfg_mask(m4), .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
        .z(z2), .match_cnt(c2));

    seq_detect_param #(.LEN(5), .PATTERN_INIT(5'b11011)) dut5 (
        .clk(clk), .rst(rst), .x_valid(x_valid), .x(x), .cfg_load(cfg_load),
        .cfg_pattern(p5), .cfg_mask(m5), .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
        .z(z5), .match_cnt(c5));

    // Reference model: per build, the queue holds the bits eligible to form a match.
    int          nvec = 0, nerr = 0;
    bit          q[3][$];
    logic [31:0] mpat[3], mmask[3];
    bit          movl[3], mz[3];
    int          mcnt[3];
    int          mlen[3] = '{4, 4, 5};
    int          mmax[3] = '{255, 3, 255};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit hit(input int k);
        for (int i = 0; i < mlen[k]; i++) begin
            int idx = mlen[k] - 1 - i;
            if (mmask[k][idx] && (q[k][i] != mpat[k][idx])) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            bit m;
            m = 1'b0;
            if (rst) begin
                q[k].delete();
                mz[k]    = 1'b0;
                mcnt[k]  = 0;
                mpat[k]  = (k == 2) ? 32'b11011 : 32'b0110;
                mmask[k] = (32'd1 << mlen[k]) - 32'd1;
                movl[k]  = 1'b1;
            end else begin
                if (cfg_load) begin
                    q[k].delete();
                    mpat[k]  = (k == 2) ? 32'(p5) : 32'(p4);
                    mmask[k] = (k == 2) ? 32'(m5) : 32'(m4);
                    movl[k]  = cfg_overlap;
                end else if (x_valid) begin
                    q[k].push_back(x);
                    if (q[k].size() > mlen[k]) void'(q[k].pop_front());
                    if (q[k].size() == mlen[k] && hit(k)) m = 1'b1;
                    if (m && !movl[k]) q[k].delete();
                end
                mz[k] = m;
                if (cnt_clr) mcnt[k] = 0;
                else if (m && mcnt[k] < mmax[k]) mcnt[k]++;
            end
        end
    endtask

    task automatic step(input logic r, input logic v, input logic b,
                        input logic ld, input logic clr);
        rst = r; x_valid = v; x = b; cfg_load = ld; cnt_clr = clr;
        @(posedge clk);
        model_edge();
        #1;
        chk("z4", 32'(z4), 32'(mz[0]));
        chk("z2", 32'(z2), 32'(mz[1]));
        chk("z5", 32'(z5), 32'(mz[2]));
        chk("cnt4", 32'(c4), 32'(mcnt[0]));
        chk("cnt2", 32'(c2), 32'(mcnt[1]));
        chk("cnt5", 32'(c5), 32'(mcnt[2]));
    endtask

    task automatic stream(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) step(1'b0, 1'b1, bits[i], 1'b0, 1'b0);
    endtask

    task automatic load(input logic [3:0] pa, input logic [3:0] ma,
                        input logic [4:0] pb, input logic [4:0] mb, input logic ov);
        p4 = pa; m4 = ma; p5 = pb; m5 = mb; cfg_overlap = ov;
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        p4 = 4'b0110; m4 = 4'hf; p5 = 5'b11011; m5 = 5'h1f; cfg_overlap = 1'b1;
        // Reset with live-looking inputs that must be ignored
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst_z", 32'(z4), 32'd0);
        chk("rst_cnt", 32'(c4), 32'd0);

        stream(16'b0011_0110_0110, 12);
        chk("cnt_ovl4", 32'(c4), 32'd3);

        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        load(4'b0110, 4'hf, 5'b11011, 5'h1f, 1'b0);
        stream(16'b0011_0110_0110, 12);
        chk("cnt_novl4", 32'(c4), 32'd2);

        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        load(4'b0110, 4'hf, 5'b11011, 5'h1f, 1'b1);
        stream(16'b1101_1011, 8);
        chk("cnt_ovl5", 32'(c5), 32'd2);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        load(4'b0110, 4'hf, 5'b11011, 5'h1f, 1'b0);
        stream(16'b1101_1011, 8);
        chk("cnt_novl5", 32'(c5), 32'd1);

        // Valid gaps do not break a partial pattern
        load(4'b0110, 4'hf, 5'b11011, 5'h1f, 1'b1);
        stream(16'b01, 2);
        repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        stream(16'b1, 1);
        chk("gap_pre", 32'(z4), 32'd0);
        stream(16'b0, 1);
        chk("gap_hit", 32'(z4), 32'd1);
        // cfg_load mid-pattern flushes; the bit presented with it is dropped
        stream(16'b011, 3);
        p4 = 4'b0110; m4 = 4'hf; cfg_overlap = 1'b1;
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        stream(16'b0110, 4);
        chk("ld_flush", 32'(z4), 32'd1);

        // Don't-care mask
        load(4'b0000, 4'b1001, 5'b00000, 5'b10001, 1'b1);
        stream(16'b0100, 4);
        chk("mask_hit", 32'(z4), 32'd1);
        load(4'b0000, 4'b1001, 5'b00000, 5'b10001, 1'b1);
        stream(16'b0011, 4);
        chk("mask_miss", 32'(z4), 32'd0);

        // Saturation on the 2-bit counter, then clear colliding with a match
        load(4'b0110, 4'hf, 5'b11011, 5'h1f, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        stream(16'b0110_1101_1011_0110, 16);
        chk("sat2", 32'(c2), 32'd3);
        stream(16'b011, 3);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("clr_z", 32'(z2), 32'd1);
        chk("clr_cnt", 32'(c2), 32'd0);

        // Reset mid-pattern
        stream(16'b011, 3);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        stream(16'b0, 1);
        chk("rst_mid", 32'(z4), 32'd0);

        for (int i = 0; i < 600; i++) begin
            logic r, ld;
            r  = ($urandom_range(99) == 0);
            ld = ($urandom_range(99) < 3);
            if (ld) begin
                p4 = 4'($urandom); m4 = 4'($urandom); cfg_overlap = 1'($urandom);
                p5 = 5'($urandom); m5 = 5'($urandom);
            end
            step(r, ($urandom_range(3) != 0), 1'($urandom), ld,
                 ($urandom_range(19) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
